ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_if.sv | 26 ++
 rtl/ex_muldiv.sv | 152 +++++++++++++++
 tb/tb_ex_muldiv.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// EX-stage multiply/divide unit port bundle.
// master drives requests and operands; slave is the HI/LO unit.
interface ex_muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wdata;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, opa, opb, hi_wr, lo_wr, wdata, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, opa, opb, hi_wr, lo_wr, wdata, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv.sv
// EX-stage HI/LO unit: 2-cycle mult/multu, optional 33-cycle div/divu.
// Define MULDIV_DIV_EN to build the restoring divider (DIV/FIX states).
module ex_muldiv (
    input logic        clk,
    input logic        rst_n,
    ex_muldiv_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
`ifdef MULDIV_DIV_EN
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;
`endif

    logic [1:0]  state;
    logic [1:0]  op_q;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [4:0]  cnt;
    logic [63:0] prod;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;
    logic        accept;
    logic [31:0] b_in;

    logic        sgn;
    logic [63:0] mx;
    logic [63:0] my;
    logic [63:0] mp;

    // Low 64 bits of the extended product serve both signed and unsigned.
    assign sgn = (op_q == 2'b00);
    assign mx  = {{32{sgn & opa_q[31]}}, opa_q};
    assign my  = {{32{sgn & opb_q[31]}}, opb_q};
    assign mp  = mx * my;

`ifdef MULDIV_DIV_EN
    logic [31:0] rem;
    logic [31:0] quo;
    logic        b_neg;
    logic        sdiv;
    logic        dbz;
    logic [31:0] a_mag;
    logic [32:0] diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign accept = bus.start && !bus.flush;
    assign a_mag  = (bus.op == 2'b10 && bus.opa[31]) ? -bus.opa : bus.opa;
    assign b_in   = (bus.op == 2'b10 && bus.opb[31]) ? -bus.opb : bus.opb;
    assign sdiv   = (op_q == 2'b10);
    assign dbz    = (opb_q == 32'd0);
    assign diff   = {rem, quo[31]} - {1'b0, opb_q};
    assign q_fix  = (sdiv && (opa_q[31] ^ b_neg)) ? -quo : quo;
    assign r_fix  = (sdiv && opa_q[31]) ? -rem : rem;
`else
    assign accept = bus.start && !bus.flush && !bus.op[1];
    assign b_in   = bus.opb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= 2'b00;
            opa_q  <= 32'd0;
            opb_q  <= 32'd0;
            cnt    <= 5'd0;
            prod   <= 64'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            rem    <= 32'd0;
            quo    <= 32'd0;
            b_neg  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (accept) begin
                            op_q  <= bus.op;
                            opa_q <= bus.opa;
                            opb_q <= b_in;
`ifdef MULDIV_DIV_EN
                            rem   <= 32'd0;
                            quo   <= a_mag;
                            b_neg <= (bus.op == 2'b10) && bus.opb[31];
                            if (bus.op[1]) begin
                                state <= S_DIV;
                                cnt   <= 5'd31;
                            end else
`endif
                            begin
                                state <= S_MUL;
                                cnt   <= 5'd1;
                            end
                        end else begin
                            if (bus.hi_wr) hi_q <= bus.wdata;
                            if (bus.lo_wr) lo_q <= bus.wdata;
                        end
                    end
                    S_MUL: begin
                        if (cnt != 5'd0) begin
                            prod <= mp;
                            cnt  <= 5'd0;
                        end else begin
                            hi_q   <= prod[63:32];
                            lo_q   <= prod[31:0];
                            done_q <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end
`ifdef MULDIV_DIV_EN
                    S_DIV: begin
                        if (!diff[32]) begin
                            rem <= diff[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= {rem[30:0], quo[31]};
                            quo <= {quo[30:0], 1'b0};
                        end
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd0) state <= S_FIX;
                    end
                    S_FIX: begin
                        if (dbz) begin
                            hi_q <= opa_q;
                            lo_q <= 32'hFFFF_FFFF;
                        end else begin
                            hi_q <= r_fix;
                            lo_q <= q_fix;
                        end
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: multiply, HI/LO moves, flush, reset,
// and divide when MULDIV_DIV_EN is defined (otherwise op 1x must be ignored).
module tb_ex_muldiv;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic seen_done;

    ex_muldiv_if bus ();

    ex_muldiv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.opa   = 32'd0;
        bus.opb   = 32'd0;
        bus.hi_wr = 1'b0;
        bus.lo_wr = 1'b0;
        bus.wdata = 32'd0;
        bus.flush = 1'b0;
    endtask

    task automatic go(input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        seen_done = 1'b0;
        rst_n = 1'b0;
        idle_in();
        #3;
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // mult -2*3 with a competing start and HI/LO writes while busy
        go(2'b00, 32'hFFFF_FFFE, 32'd3);
        tick();
        check("mul_busy_e0", {31'd0, bus.busy}, 32'd1);
        go(2'b01, 32'd5, 32'd5);
        bus.hi_wr = 1'b1;
        bus.lo_wr = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        tick();
        check("mul_busy_e1", {31'd0, bus.busy}, 32'd1);
        idle_in();
        tick();
        check("mul_busy_e2", {31'd0, bus.busy}, 32'd0);
        check("mul_done", {31'd0, bus.done}, 32'd1);
        check("mul_hi", bus.hi, 32'hFFFF_FFFF);
        check("mul_lo", bus.lo, 32'hFFFF_FFFA);
        tick();
        check("mul_done_e3", {31'd0, bus.done}, 32'd0);

        go(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        idle_in();
        tick();
        tick();
        check("multu_hi", bus.hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.lo, 32'h0000_0001);

        bus.hi_wr = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        tick();
        idle_in();
        check("mthi_hi", bus.hi, 32'hA5A5_A5A5);
        check("mthi_lo", bus.lo, 32'h0000_0001);

        bus.hi_wr = 1'b1;
        bus.lo_wr = 1'b1;
        bus.wdata = 32'h0F0F_0F0F;
        tick();
        idle_in();
        check("mtboth_hi", bus.hi, 32'h0F0F_0F0F);
        check("mtboth_lo", bus.lo, 32'h0F0F_0F0F);

        // start beats a simultaneous HI/LO write
        go(2'b01, 32'd2, 32'd3);
        bus.hi_wr = 1'b1;
        bus.lo_wr = 1'b1;
        bus.wdata = 32'hFFFF_0000;
        tick();
        idle_in();
        check("startwin_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        tick();
        check("startwin_hi", bus.hi, 32'd0);
        check("startwin_lo", bus.lo, 32'd6);

        go(2'b00, 32'h8000_0000, 32'h8000_0000);
        tick();
        idle_in();
        tick();
        tick();
        check("mulmin_hi", bus.hi, 32'h4000_0000);
        check("mulmin_lo", bus.lo, 32'h0000_0000);

        go(2'b00, 32'd7, 32'd7);
        tick();
        idle_in();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        tick();
        check("flush_done", {31'd0, bus.done}, 32'd0);
        check("flush_hi", bus.hi, 32'h4000_0000);
        check("flush_lo", bus.lo, 32'h0000_0000);

        go(2'b00, 32'd9, 32'd9);
        bus.flush = 1'b1;
        tick();
        idle_in();
        check("flush_start_busy", {31'd0, bus.busy}, 32'd0);

`ifdef MULDIV_DIV_EN
        go(2'b10, 32'hFFFF_FFF9, 32'd2);
        tick();
        idle_in();
        for (int i = 1; i <= 32; i++) tick();
        check("div_busy_e32", {31'd0, bus.busy}, 32'd1);
        tick();
        check("div_busy_e33", {31'd0, bus.busy}, 32'd0);
        check("div_done", {31'd0, bus.done}, 32'd1);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);
        tick();
        check("div_done_e34", {31'd0, bus.done}, 32'd0);

        go(2'b11, 32'd100, 32'd0);
        tick();
        idle_in();
        for (int i = 1; i <= 4; i++) tick();
        go(2'b00, 32'd1, 32'd1);
        tick();
        idle_in();
        for (int i = 6; i <= 33; i++) tick();
        check("dbz_done", {31'd0, bus.done}, 32'd1);
        check("dbz_lo", bus.lo, 32'hFFFF_FFFF);
        check("dbz_hi", bus.hi, 32'd100);

        go(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        idle_in();
        for (int i = 1; i <= 33; i++) tick();
        check("ovf_lo", bus.lo, 32'h8000_0000);
        check("ovf_hi", bus.hi, 32'd0);

        bus.hi_wr = 1'b1;
        bus.lo_wr = 1'b1;
        bus.wdata = 32'h0000_0055;
        tick();
        idle_in();
        go(2'b11, 32'd50, 32'd7);
        tick();
        idle_in();
        for (int i = 1; i <= 10; i++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("dflush_busy", {31'd0, bus.busy}, 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.done) seen_done = 1'b1;
        end
        check("dflush_done", {31'd0, seen_done}, 32'd0);
        check("dflush_hi", bus.hi, 32'h0000_0055);
        check("dflush_lo", bus.lo, 32'h0000_0055);
        bus.lo_wr = 1'b1;
        bus.wdata = 32'h1234_5678;
        tick();
        idle_in();
        check("mtlo_lo", bus.lo, 32'h1234_5678);

        go(2'b11, 32'd1000, 32'd3);
        tick();
        idle_in();
        for (int i = 1; i <= 19; i++) tick();
        rst_n = 1'b0;
        #1;
        check("drst_hi", bus.hi, 32'd0);
        check("drst_lo", bus.lo, 32'd0);
        check("drst_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) seen_done = 1'b1;
        end
        check("drst_done", {31'd0, seen_done}, 32'd0);
        check("drst_lo_after", bus.lo, 32'd0);
`else
        go(2'b10, 32'd9, 32'd3);
        tick();
        check("nodiv_busy", {31'd0, bus.busy}, 32'd0);
        idle_in();
        seen_done = 1'b0;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (bus.done) seen_done = 1'b1;
        end
        check("nodiv_done", {31'd0, seen_done}, 32'd0);
        check("nodiv_hi", bus.hi, 32'h4000_0000);
        check("nodiv_lo", bus.lo, 32'h0000_0000);
`endif

        go(2'b00, 32'd3, 32'd3);
        tick();
        idle_in();
        rst_n = 1'b0;
        #1;
        check("mrst_hi", bus.hi, 32'd0);
        check("mrst_lo", bus.lo, 32'd0);
        check("mrst_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done) seen_done = 1'b1;
        end
        check("mrst_done", {31'd0, seen_done}, 32'd0);
        check("mrst_lo_after", bus.lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
